// File: rtl/scalar_register.sv
// Enable-gated N-bit storage register for one scalar operand.
// Synchronous active-high reset clears it; output comes straight from the flop.
module scalar_register #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] data_in,
    output logic [N-1:0] data_out
);

    // Reset takes priority over a simultaneous write.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
        end else if (en) begin
            data_out <= data_in;
        end
    end

endmodule

// File: tb/tb_scalar_register.sv
// Directed bench for scalar_register (N = 4) with a queue-based scoreboard.
module tb_scalar_register;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [N-1:0] data_in;
    logic [N-1:0] data_out;

    logic [N-1:0] exp_q[$];
    logic [N-1:0] model;
    logic [N-1:0] old_val;
    int           total = 0;
    int           bad   = 0;

    always #5 clk = ~clk;

    scalar_register #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .data_in  (data_in),
        .data_out (data_out)
    );

    task automatic check(input string tag, input logic [N-1:0] expv);
        total++;
        assert (data_out === expv) else begin
            bad++;
            $error("FAIL %s got=%b exp=%b", tag, data_out, expv);
        end
    endtask

    // Drive inputs on the falling edge and record what the next rising edge should produce.
    task automatic drive(input logic r, input logic e, input logic [N-1:0] d);
        @(negedge clk);
        rst     = r;
        en      = e;
        data_in = d;
        if (r) model = '0;
        else if (e) model = d;
        exp_q.push_back(model);
    endtask

    task automatic settle(input string tag);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s got=%b exp=<empty queue>", tag, data_out);
        end else begin
            check(tag, exp_q.pop_front());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b0;
        en      = 1'b0;
        data_in = '0;
        model   = 'x;

        drive(1'b1, 1'b0, 4'b0110);
        settle("reset_state");

        drive(1'b0, 1'b0, 4'b1100);
        settle("no_write_en0");
        total++;
        assert (data_out !== 4'b1100) else begin
            bad++;
            $error("FAIL no_write_ne got=%b exp=not 1100", data_out);
        end

        drive(1'b0, 1'b1, 4'b1100);
        settle("write_1100");

        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 4'b1111);
            settle($sformatf("hold_%0d", i));
        end

        drive(1'b0, 1'b1, 4'b1111);
        settle("overwrite_1111");

        drive(1'b0, 1'b1, 4'b0001);
        settle("b2b_0001");
        drive(1'b0, 1'b1, 4'b0010);
        settle("b2b_0010");

        drive(1'b0, 1'b0, 4'b0111);
        settle("hold_0010");

        drive(1'b1, 1'b0, 4'b0101);
        settle("sync_reset");

        drive(1'b0, 1'b1, 4'b1001);
        settle("write_1001");

        drive(1'b1, 1'b1, 4'b1010);
        settle("reset_priority");

        drive(1'b0, 1'b1, 4'b0110);
        settle("write_0110");

        // Reset raised mid-cycle must not clear the register until the edge.
        old_val = model;
        drive(1'b1, 1'b0, 4'b0000);
        #4;
        check("reset_pre_edge", old_val);
        settle("reset_post_edge");

        drive(1'b0, 1'b0, 4'b1111);
        settle("hold_after_reset");

        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL queue_empty got=%0d exp=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
